// File: rtl/gzip_trailer.sv
// gzip_trailer
// Produces the GZIP member trailer once the deflate payload has ended. The
// trailer is CRC32 followed by ISIZE, both little-endian.
// While idle, the block counts the uncompressed input bytes (ISIZE, modulo 2^32).
// On trailer_start it freezes that count. It then waits for a valid CRC from the
// crc32 block and streams the trailer bytes to the output byte mux.
//
// Ports
//   clk             single clock
//   rst_n           asynchronous active-low reset
//   byte_valid_in   one uncompressed byte accepted this cycle (counted in IDLE)
//   trailer_start   single-cycle pulse: end of member data
//   crc32_in        final CRC from crc32_out
//   crc32_valid_in  crc32_in is valid
//   out_ready       downstream accepts gzip_out this cycle
//   gzip_out        trailer byte
//   gzip_valid_out  gzip_out is valid
//   trailer_done    one-cycle pulse after the last trailer byte transfers
//   busy            high in every state except IDLE
//
// Handshake: a byte transfers on every rising clk edge where gzip_valid_out and
// out_ready are both 1. While gzip_valid_out=1 and out_ready=0, gzip_out holds.
// gzip_valid_out never depends combinationally on out_ready.
module gzip_trailer #(
    parameter bit INCLUDE_ISIZE = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        byte_valid_in,
    input  logic        trailer_start,
    input  logic [31:0] crc32_in,
    input  logic        crc32_valid_in,
    input  logic        out_ready,
    output logic [7:0]  gzip_out,
    output logic        gzip_valid_out,
    output logic        trailer_done,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_CRC = 2'd1,
        SEND     = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [2:0] LAST_IDX = INCLUDE_ISIZE ? 3'd7 : 3'd3;

    state_t      state_q, state_d;
    logic [31:0] isize_cnt_q, isize_cnt_d;
    logic [31:0] isize_q, isize_d;
    logic [31:0] crc_q, crc_d;
    logic [2:0]  idx_q, idx_d;

    logic [7:0]  gzip_out_d;
    logic        gzip_valid_d;
    logic        trailer_done_d;
    logic        busy_d;

    logic        xfer;
    logic [63:0] trailer_word;

    // gzip_valid_out is high exactly while the FSM is in SEND.
    assign xfer = gzip_valid_out && out_ready;

    // State and datapath registers. The output registers are loaded here as well.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            isize_cnt_q    <= 32'd0;
            isize_q        <= 32'd0;
            crc_q          <= 32'd0;
            idx_q          <= 3'd0;
            gzip_out       <= 8'h00;
            gzip_valid_out <= 1'b0;
            trailer_done   <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state_q        <= state_d;
            isize_cnt_q    <= isize_cnt_d;
            isize_q        <= isize_d;
            crc_q          <= crc_d;
            idx_q          <= idx_d;
            gzip_out       <= gzip_out_d;
            gzip_valid_out <= gzip_valid_d;
            trailer_done   <= trailer_done_d;
            busy           <= busy_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        isize_cnt_d = isize_cnt_q;
        isize_d     = isize_q;
        crc_d       = crc_q;
        idx_d       = idx_q;
        case (state_q)
            IDLE: begin
                if (byte_valid_in) begin
                    isize_cnt_d = isize_cnt_q + 32'd1;
                end
                if (trailer_start) begin
                    // A byte that arrives together with trailer_start belongs to the member.
                    isize_d = isize_cnt_q + {31'd0, byte_valid_in};
                    state_d = WAIT_CRC;
                end
            end
            WAIT_CRC: begin
                if (crc32_valid_in) begin
                    crc_d   = crc32_in;
                    idx_d   = 3'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            DONE: begin
                isize_cnt_d = 32'd0;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode. The outputs are computed from the next-state values, so each
    // registered output is aligned with the state it describes.
    assign trailer_word = {isize_d, crc_d};

    always_comb begin
        gzip_out_d     = 8'h00;
        gzip_valid_d   = 1'b0;
        trailer_done_d = 1'b0;
        busy_d         = (state_d != IDLE);
        if (state_d == SEND) begin
            gzip_valid_d = 1'b1;
            gzip_out_d   = trailer_word[{idx_d, 3'b000} +: 8];
        end
        if (state_d == DONE) begin
            trailer_done_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_gzip_trailer.sv
module tb_gzip_trailer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // DUT with ISIZE
    logic        byte_valid = 1'b0;
    logic        trailer_start = 1'b0;
    logic [31:0] crc = 32'd0;
    logic        crc_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  gzip_out;
    logic        gzip_valid_out;
    logic        trailer_done;
    logic        busy;

    // DUT without ISIZE
    logic        n_byte_valid = 1'b0;
    logic        n_start = 1'b0;
    logic [31:0] n_crc = 32'd0;
    logic        n_crc_valid = 1'b0;
    logic        n_ready = 1'b0;
    logic [7:0]  n_out;
    logic        n_valid;
    logic        n_done;
    logic        n_busy;

    logic [7:0]  exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    gzip_trailer #(.INCLUDE_ISIZE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .byte_valid_in(byte_valid),
        .trailer_start(trailer_start), .crc32_in(crc), .crc32_valid_in(crc_valid),
        .out_ready(out_ready), .gzip_out(gzip_out), .gzip_valid_out(gzip_valid_out),
        .trailer_done(trailer_done), .busy(busy)
    );

    gzip_trailer #(.INCLUDE_ISIZE(1'b0)) dut_n (
        .clk(clk), .rst_n(rst_n), .byte_valid_in(n_byte_valid),
        .trailer_start(n_start), .crc32_in(n_crc), .crc32_valid_in(n_crc_valid),
        .out_ready(n_ready), .gzip_out(n_out), .gzip_valid_out(n_valid),
        .trailer_done(n_done), .busy(n_busy)
    );

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed_bytes(input int n);
        byte_valid = 1'b1;
        repeat (n) tick();
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start(input logic coinc);
        trailer_start = 1'b1;
        byte_valid    = coinc;
        tick();
        trailer_start = 1'b0;
        byte_valid    = 1'b0;
    endtask

    // Scoreboard: trailer bytes in RFC 1952 order
    task automatic push_trailer(input logic [31:0] c, input logic [31:0] isz, input bit incl);
        for (int i = 0; i < 4; i++) exp_q.push_back(c[8*i +: 8]);
        if (incl) begin
            for (int i = 0; i < 4; i++) exp_q.push_back(isz[8*i +: 8]);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        @(negedge clk);
        n_checks++;
        if ({gzip_out, gzip_valid_out, trailer_done, busy} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got out=%02h v=%b d=%b b=%b expected all 0",
                     gzip_out, gzip_valid_out, trailer_done, busy);
        end
        n_checks++;
        if ({n_out, n_valid, n_done, n_busy} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_outputs_n: got out=%02h v=%b d=%b b=%b expected all 0",
                     n_out, n_valid, n_done, n_busy);
        end
        rst_n = 1'b1;
        tick();
    endtask

    // "0123456789", ready held high: exact cycle timing
    task automatic test_basic();
        logic [7:0] e;
        crc       = 32'hA684C7C6;
        crc_valid = 1'b1;
        out_ready = 1'b1;
        feed_bytes(10);
        push_trailer(32'hA684C7C6, 32'd10, 1'b1);
        pulse_start(1'b0);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || gzip_valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_wait_cycle: got busy=%b valid=%b expected busy=1 valid=0",
                     busy, gzip_valid_out);
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (gzip_valid_out !== 1'b1 || gzip_out !== e) begin
                n_fail++;
                $display("FAIL basic_byte%0d: got valid=%b byte=%02h expected valid=1 byte=%02h",
                         k, gzip_valid_out, gzip_out, e);
            end
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (trailer_done !== 1'b1 || gzip_valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: got done=%b valid=%b expected done=1 valid=0",
                     trailer_done, gzip_valid_out);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (trailer_done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle: got done=%b busy=%b expected 0 0", trailer_done, busy);
        end
        exp_q.delete();
    endtask

    // Quick brown fox, ready pattern 1,0,0,1,0,0...
    task automatic test_stall();
        logic [7:0] e;
        logic [7:0] held;
        logic       stalled;
        int         cyc;
        stalled = 1'b0;
        held    = 8'h00;
        crc     = 32'h414FA339;
        feed_bytes(43);
        push_trailer(32'h414FA339, 32'd43, 1'b1);
        pulse_start(1'b0);
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 100) begin
            out_ready = (cyc % 3 == 0);
            @(negedge clk);
            if (gzip_valid_out) begin
                if (stalled) begin
                    n_checks++;
                    if (gzip_out !== held) begin
                        n_fail++;
                        $display("FAIL stall_hold: got %02h expected %02h", gzip_out, held);
                    end
                end
                if (out_ready) begin
                    e = exp_q.pop_front();
                    n_checks++;
                    if (gzip_out !== e) begin
                        n_fail++;
                        $display("FAIL stall_byte: got %02h expected %02h", gzip_out, e);
                    end
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = gzip_out;
                end
            end
            tick();
            cyc++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL stall_timeout: got %0d bytes left expected 0", exp_q.size());
            exp_q.delete();
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (trailer_done !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_done: got %b expected 1", trailer_done);
        end
        tick();
    endtask

    // Zero-length member, then byte coincident with start after 31 bytes
    task automatic test_boundaries();
        logic [7:0] e;
        int         cyc;
        for (int m = 0; m < 2; m++) begin
            out_ready = 1'b1;
            if (m == 0) begin
                crc = 32'h00000000;
                push_trailer(32'h00000000, 32'd0, 1'b1);
                pulse_start(1'b0);
            end else begin
                crc = 32'h12345678;
                feed_bytes(31);
                push_trailer(32'h12345678, 32'd32, 1'b1);
                pulse_start(1'b1);
            end
            cyc = 0;
            while (exp_q.size() > 0 && cyc < 40) begin
                @(negedge clk);
                if (gzip_valid_out && out_ready) begin
                    e = exp_q.pop_front();
                    n_checks++;
                    if (gzip_out !== e) begin
                        n_fail++;
                        $display("FAIL boundary%0d_byte: got %02h expected %02h", m, gzip_out, e);
                    end
                end
                tick();
                cyc++;
            end
            n_checks++;
            if (exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL boundary%0d_timeout: got %0d bytes left expected 0", m, exp_q.size());
                exp_q.delete();
            end
            @(negedge clk);
            n_checks++;
            if (trailer_done !== 1'b1) begin
                n_fail++;
                $display("FAIL boundary%0d_done: got %b expected 1", m, trailer_done);
            end
            tick();
        end
    endtask

    // CRC late by 5 cycles; bytes outside IDLE are ignored
    task automatic test_wait_crc();
        logic [7:0] e;
        int         cyc;
        crc_valid = 1'b0;
        out_ready = 1'b1;
        feed_bytes(5);
        pulse_start(1'b0);
        byte_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if (gzip_valid_out !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL wait_crc%0d: got valid=%b busy=%b expected valid=0 busy=1",
                         k, gzip_valid_out, busy);
            end
            tick();
        end
        crc       = 32'hCAFEF00D;
        crc_valid = 1'b1;
        push_trailer(32'hCAFEF00D, 32'd5, 1'b1);
        push_trailer(32'h0BADBEEF, 32'd3, 1'b1);
        for (int m = 0; m < 2; m++) begin
            cyc = 0;
            while (exp_q.size() > (m == 0 ? 8 : 0) && cyc < 40) begin
                @(negedge clk);
                if (gzip_valid_out && out_ready) begin
                    e = exp_q.pop_front();
                    n_checks++;
                    if (gzip_out !== e) begin
                        n_fail++;
                        $display("FAIL wait%0d_byte: got %02h expected %02h", m, gzip_out, e);
                    end
                end
                tick();
                cyc++;
            end
            byte_valid = 1'b0;
            n_checks++;
            if (exp_q.size() != (m == 0 ? 8 : 0)) begin
                n_fail++;
                $display("FAIL wait%0d_timeout: got %0d bytes left", m, exp_q.size());
                exp_q.delete();
            end
            @(negedge clk);
            n_checks++;
            if (trailer_done !== 1'b1) begin
                n_fail++;
                $display("FAIL wait%0d_done: got %b expected 1", m, trailer_done);
            end
            tick();
            if (m == 0) begin
                crc = 32'h0BADBEEF;
                feed_bytes(3);
                pulse_start(1'b0);
            end
        end
    endtask

    // Reset mid-trailer, then a fresh 32 x 0x00 member
    task automatic test_reset_mid();
        logic [7:0] e;
        int         cyc;
        int         done_seen;
        crc       = 32'h11223344;
        out_ready = 1'b1;
        feed_bytes(10);
        push_trailer(32'h11223344, 32'd10, 1'b1);
        pulse_start(1'b0);
        tick();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (gzip_out !== e) begin
                n_fail++;
                $display("FAIL rstmid_byte%0d: got %02h expected %02h", k, gzip_out, e);
            end
            tick();
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({gzip_out, gzip_valid_out, trailer_done, busy} !== 11'd0) begin
            n_fail++;
            $display("FAIL rstmid_clear: got out=%02h v=%b d=%b b=%b expected all 0",
                     gzip_out, gzip_valid_out, trailer_done, busy);
        end
        exp_q.delete();
        tick();
        rst_n     = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (trailer_done) done_seen++;
            tick();
        end
        n_checks++;
        if (done_seen != 0) begin
            n_fail++;
            $display("FAIL rstmid_no_done: got %0d pulses expected 0", done_seen);
        end
        crc = 32'h190A55AD;
        feed_bytes(32);
        push_trailer(32'h190A55AD, 32'd32, 1'b1);
        pulse_start(1'b0);
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 40) begin
            @(negedge clk);
            if (gzip_valid_out && out_ready) begin
                e = exp_q.pop_front();
                n_checks++;
                if (gzip_out !== e) begin
                    n_fail++;
                    $display("FAIL rstmid_fresh_byte: got %02h expected %02h", gzip_out, e);
                end
            end
            tick();
            cyc++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rstmid_timeout: got %0d bytes left expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        n_checks++;
        if (trailer_done !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_fresh_done: got %b expected 1", trailer_done);
        end
        tick();
    endtask

    // CRC-only variant, 32 x 0xFF
    task automatic test_no_isize();
        logic [7:0] e;
        n_crc        = 32'hFF6CAB0B;
        n_crc_valid  = 1'b1;
        n_ready      = 1'b1;
        n_byte_valid = 1'b1;
        repeat (32) tick();
        n_byte_valid = 1'b0;
        push_trailer(32'hFF6CAB0B, 32'd32, 1'b0);
        n_start = 1'b1;
        tick();
        n_start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (n_valid !== 1'b0 || n_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL noisize_wait: got valid=%b busy=%b expected 0 1", n_valid, n_busy);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (n_valid !== 1'b1 || n_out !== e) begin
                n_fail++;
                $display("FAIL noisize_byte%0d: got valid=%b byte=%02h expected valid=1 byte=%02h",
                         k, n_valid, n_out, e);
            end
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (n_done !== 1'b1 || n_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL noisize_done: got done=%b valid=%b expected 1 0", n_done, n_valid);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (n_done !== 1'b0 || n_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL noisize_idle: got done=%b busy=%b expected 0 0", n_done, n_busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_boundaries();
        test_wait_crc();
        test_reset_mid();
        test_no_isize();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gzip_trailer.md
# gzip_trailer

Generates the 8-byte GZIP member trailer (RFC 1952: CRC32 then ISIZE, both little-endian) after the deflate payload. Sits beside `crc32` in the GZIP path: observes the same byte strobe that feeds `crc32`, counts input bytes, latches the final `crc32_out`, then streams the trailer bytes to the output byte mux over a valid/ready handshake.

## Interface

- `INCLUDE_ISIZE`, default 1: 1 emits CRC32 + ISIZE (8 bytes); 0 emits CRC32 only (4 bytes).

Ports:

- `clk`, input, 1: single clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `byte_valid_in`, input, 1: one uncompressed input byte accepted this cycle. Same strobe as `crc32_valid_in`.
- `trailer_start`, input, 1: single-cycle pulse marking end of member data.
- `crc32_in`, input, 32: connected to `crc32_out`.
- `crc32_valid_in`, input, 1: connected to `crc32_valid_out`.
- `out_ready`, input, 1: downstream accepts `gzip_out` this cycle.
- `gzip_out`, output, 8: trailer byte.
- `gzip_valid_out`, output, 1: `gzip_out` is valid.
- `trailer_done`, output, 1: one-cycle pulse after the last trailer byte transfers.
- `busy`, output, 1: high in every state except IDLE.

## Operation

- States: IDLE, WAIT_CRC, SEND, DONE.
- IDLE:
  - `byte_valid_in` increments the 32-bit `isize_cnt`, wrapping modulo 2^32 (0xFFFFFFFF + 1 = 0).
  - `trailer_start` latches ISIZE and moves to WAIT_CRC.
  - If `byte_valid_in` and `trailer_start` occur in the same cycle, that byte is counted and the latched ISIZE includes it.
- WAIT_CRC:
  - On the first cycle with `crc32_valid_in`=1, latch `crc32_in` and go to SEND with byte index 0.
  - Earliest latch is the cycle after `trailer_start`, so the last byte's CRC update is included.
  - Waits indefinitely while `crc32_valid_in`=0.
- SEND:
  - `gzip_valid_out`=1.
  - Byte order: CRC[7:0], CRC[15:8], CRC[23:16], CRC[31:24], then (if `INCLUDE_ISIZE`) ISIZE[7:0], [15:8], [23:16], [31:24].
  - The index advances only on a transfer (`gzip_valid_out` && `out_ready`).
  - After transfer of the last byte (index 7, or index 3 when `INCLUDE_ISIZE`=0), go to DONE.
- DONE: `trailer_done`=1 for exactly one cycle. `isize_cnt` clears to 0. Return to IDLE.
- Ignored inputs:
  - `byte_valid_in` outside IDLE: not counted.
  - `trailer_start` outside IDLE.
- Reset asserted in any state: immediately return to IDLE and clear the counter, latches, index, and all outputs. A trailer in flight is abandoned; no partial `trailer_done`.

## Timing

- Reset values: `gzip_out`=0x00, `gzip_valid_out`=0, `trailer_done`=0, `busy`=0. Internal: `isize_cnt`=0, state IDLE.
- All outputs are registered; no combinational path from `out_ready` to `gzip_valid_out` or `gzip_out`.
- `busy` rises the cycle after `trailer_start` is sampled.
- With `crc32_valid_in` already high, `gzip_valid_out` rises 2 cycles after the `trailer_start` edge.
- `gzip_out` holds stable while `gzip_valid_out`=1 and `out_ready`=0.
- With `out_ready` held at 1: one byte per cycle, 8 consecutive transfer cycles. `trailer_done` is in the cycle after the last transfer; IDLE follows.
- `gzip_valid_out` drops in the DONE cycle; there are no bubbles between bytes under continuous ready.
- Minimum gap between consecutive `trailer_start` pulses: the trailer length + 3 cycles.

## Test plan

- "0123456789" (10 bytes, CRC 0xA684C7C6), `out_ready`=1 → bytes C6 C7 84 A6 0A 00 00 00 on consecutive cycles, then one `trailer_done` pulse.
- "The quick brown fox jumps over the lazy dog" (43 bytes, CRC 0x414FA339), with `out_ready` toggling 1,0,0,1,... → bytes 39 A3 4F 41 2B 00 00 00 in order. Each byte stays stable through the stall cycles; no byte is duplicated or dropped.
- `trailer_start` with zero input bytes, `crc32_in`=0x00000000 → 00 00 00 00 00 00 00 00. Also: `byte_valid_in` coincident with `trailer_start` after 31 prior bytes → ISIZE byte 0 = 0x20.
- `crc32_valid_in` held low for 5 cycles after start → `gzip_valid_out` stays 0 and `busy`=1 until the CRC is valid. `byte_valid_in` pulses during SEND do not change the next member's ISIZE, which starts at 0.
- `rst_n` pulsed low after the 3rd transferred byte → all outputs go to 0 immediately and `trailer_done` never pulses. A fresh 32×0x00 member (CRC 0x190A55AD) then yields AD 55 0A 19 20 00 00 00.
- `INCLUDE_ISIZE`=0, 32×0xFF (CRC 0xFF6CAB0B) → exactly 4 bytes 0B AB 6C FF, then `trailer_done`.
